// File: rtl/id_dp_pipe.sv
// id_dp_pipe: decode-to-datapath stage with operand forwarding, shift/immediate selection and Thumb BL pairing.
module id_dp_pipe #(
  parameter int DW   = 32,
  parameter int NFWD = 2,
  parameter int SHW  = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [15:0]       INST,
  input  logic [DW-1:0]     IF_PC,
  input  logic [DW-1:0]     RF_RD,
  input  logic [DW-1:0]     RF_RN,
  input  logic [DW-1:0]     RF_RM,
  input  logic [3:0]        SRC_X_IDX,
  input  logic [3:0]        SRC_Y_IDX,
  input  logic [1:0]        RN_SEL,
  input  logic              RM_SEL,
  input  logic [2:0]        IMM_SEL,
  input  logic [2:0]        SHT_SEL,
  input  logic              IS_BL_H1,
  input  logic              IS_BL_H2,
  input  logic [NFWD-1:0]   FWD_VALID,
  input  logic [4*NFWD-1:0] FWD_IDX,
  input  logic [DW*NFWD-1:0] FWD_DATA,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DW-1:0]     OP_X,
  output logic [DW-1:0]     OP_Y,
  output logic [SHW-1:0]    SHT_AMOUNT,
  output logic [DW-1:0]     PC_OFFSET,
  output logic              BL_PEND,
  output logic              BL_ORPHAN
);
  typedef enum logic {IDLE, H1_HELD} bl_state_t;
  bl_state_t state;
  logic [DW-1:0] bl_hi, imm, x_sel, y_sel, h1_off, bl_lo, imm_off;
  logic [7:0] sht_sel;
  logic acc, unused_inst;
  assign unused_inst = ^INST[15:11];
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign acc = IN_VALID && IN_READY && !FLUSH;
  assign BL_PEND = state == H1_HELD;
  assign h1_off = DW'($signed(INST[10:0])) << 12;
  assign bl_lo = DW'(INST[10:0]) << 1;
  assign imm_off = imm << 1;
  always_comb begin
    imm = IMM_SEL == 3'd0 ? DW'(INST[8:6]) :
          IMM_SEL == 3'd1 ? DW'(INST[10:6]) :
          IMM_SEL == 3'd2 ? DW'(INST[6:0]) :
          IMM_SEL == 3'd3 ? DW'(INST[7:0]) :
          IMM_SEL == 3'd4 ? DW'($signed(INST[7:0])) :
          IMM_SEL == 3'd5 ? DW'(INST[10:0]) :
          IMM_SEL == 3'd6 ? DW'($signed(INST[10:0])) : '0;
    x_sel = RN_SEL == 2'd0 ? IF_PC : RN_SEL == 2'd1 ? RF_RD : RN_SEL == 2'd2 ? RF_RN : '0;
    y_sel = RM_SEL ? RF_RM : imm;
    // descending scan so the lowest matching entry is the last write and wins
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (FWD_VALID[i] && FWD_IDX[4*i +: 4] == SRC_X_IDX && (RN_SEL == 2'd1 || RN_SEL == 2'd2))
        x_sel = FWD_DATA[DW*i +: DW];
      if (FWD_VALID[i] && FWD_IDX[4*i +: 4] == SRC_Y_IDX && RM_SEL)
        y_sel = FWD_DATA[DW*i +: DW];
    end
    sht_sel = SHT_SEL == 3'd0 ? {3'b0, INST[10:6]} :
              SHT_SEL == 3'd1 ? y_sel[7:0] :
              SHT_SEL == 3'd2 ? 8'd12 :
              SHT_SEL == 3'd3 ? 8'd2 :
              SHT_SEL == 3'd4 ? 8'd1 : 8'd0;
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state      <= IDLE;
      OUT_VALID  <= 1'b0;
      OP_X       <= '0;
      OP_Y       <= '0;
      SHT_AMOUNT <= '0;
      PC_OFFSET  <= '0;
      bl_hi      <= '0;
      BL_ORPHAN  <= 1'b0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
      state     <= IDLE;
    end else if (acc) begin
      OUT_VALID  <= 1'b1;
      OP_X       <= x_sel;
      OP_Y       <= y_sel;
      SHT_AMOUNT <= SHW'(sht_sel);
      if (IS_BL_H2) begin
        PC_OFFSET <= state == H1_HELD ? bl_hi + bl_lo : bl_lo;
        BL_ORPHAN <= state == IDLE;
        state     <= IDLE;
      end else if (IS_BL_H1) begin
        bl_hi     <= h1_off;
        PC_OFFSET <= h1_off;
        BL_ORPHAN <= state == H1_HELD;
        state     <= H1_HELD;
      end else begin
        PC_OFFSET <= imm_off;
        BL_ORPHAN <= state == H1_HELD;
        state     <= IDLE;
      end
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
endmodule

// File: tb/tb_id_dp_pipe.sv
// tb_id_dp_pipe: random and directed checks of id_dp_pipe against an arithmetic reference model.
module tb_id_dp_pipe;
  localparam int DW = 32, NFWD = 2, SHW = 8;
  localparam longint M = 64'h1_0000_0000;
  logic CLK = 0, RESETn = 0, IN_VALID, IN_READY, RM_SEL, IS_BL_H1, IS_BL_H2, FLUSH;
  logic OUT_VALID, OUT_READY, BL_PEND, BL_ORPHAN;
  logic [15:0] INST;
  logic [DW-1:0] IF_PC, RF_RD, RF_RN, RF_RM, OP_X, OP_Y, PC_OFFSET;
  logic [3:0] SRC_X_IDX, SRC_Y_IDX;
  logic [1:0] RN_SEL;
  logic [2:0] IMM_SEL, SHT_SEL;
  logic [NFWD-1:0] FWD_VALID;
  logic [4*NFWD-1:0] FWD_IDX;
  logic [DW*NFWD-1:0] FWD_DATA;
  logic [SHW-1:0] SHT_AMOUNT;
  int checks = 0, errors = 0;
  bit m_valid, m_pend, m_orph;
  longint m_x, m_y, m_sht, m_off, m_hi;

  id_dp_pipe #(.DW(DW), .NFWD(NFWD), .SHW(SHW)) dut (
    .CLK(CLK), .RESETn(RESETn), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INST(INST),
    .IF_PC(IF_PC), .RF_RD(RF_RD), .RF_RN(RF_RN), .RF_RM(RF_RM),
    .SRC_X_IDX(SRC_X_IDX), .SRC_Y_IDX(SRC_Y_IDX), .RN_SEL(RN_SEL), .RM_SEL(RM_SEL),
    .IMM_SEL(IMM_SEL), .SHT_SEL(SHT_SEL), .IS_BL_H1(IS_BL_H1), .IS_BL_H2(IS_BL_H2),
    .FWD_VALID(FWD_VALID), .FWD_IDX(FWD_IDX), .FWD_DATA(FWD_DATA), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OP_X(OP_X), .OP_Y(OP_Y),
    .SHT_AMOUNT(SHT_AMOUNT), .PC_OFFSET(PC_OFFSET), .BL_PEND(BL_PEND), .BL_ORPHAN(BL_ORPHAN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(longint v, int bits);
    return v >= (longint'(1) << (bits - 1)) ? v - (longint'(1) << bits) + M : v;
  endfunction

  function automatic longint imm_of(int sel, longint inst);
    case (sel)
      0: return (inst / 64) % 8;
      1: return (inst / 64) % 32;
      2: return inst % 128;
      3: return inst % 256;
      4: return sx(inst % 256, 8);
      5: return inst % 2048;
      6: return sx(inst % 2048, 11);
      default: return 0;
    endcase
  endfunction

  function automatic longint pick(longint dflt, bit en, int idx);
    for (int i = 0; i < NFWD; i++)
      if (en && FWD_VALID[i] && int'((FWD_IDX >> (4 * i)) & 15) == idx)
        return longint'(FWD_DATA[DW*i +: DW]);
    return dflt;
  endfunction

  task automatic idle_in();
    IN_VALID = 0; INST = 0; IF_PC = 0; RF_RD = 0; RF_RN = 0; RF_RM = 0;
    SRC_X_IDX = 0; SRC_Y_IDX = 0; RN_SEL = 0; RM_SEL = 0; IMM_SEL = 0; SHT_SEL = 0;
    IS_BL_H1 = 0; IS_BL_H2 = 0; FWD_VALID = 0; FWD_IDX = 0; FWD_DATA = 0;
    FLUSH = 0; OUT_READY = 1;
  endtask

  task automatic rand_in();
    IN_VALID = $urandom_range(0, 3) != 0; INST = 16'($urandom);
    IF_PC = $urandom; RF_RD = $urandom; RF_RN = $urandom; RF_RM = $urandom;
    SRC_X_IDX = 4'($urandom_range(0, 3)); SRC_Y_IDX = 4'($urandom_range(0, 3));
    RN_SEL = 2'($urandom_range(0, 2)); RM_SEL = 1'($urandom); IMM_SEL = 3'($urandom);
    SHT_SEL = 3'($urandom); IS_BL_H1 = $urandom_range(0, 5) == 0; IS_BL_H2 = $urandom_range(0, 5) == 0;
    FWD_VALID = 2'($urandom); FWD_IDX = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    FWD_DATA = {32'($urandom), 32'($urandom)}; FLUSH = $urandom_range(0, 15) == 0;
    OUT_READY = $urandom_range(0, 3) != 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_pend = 0; m_orph = 0; m_x = 0; m_y = 0; m_sht = 0; m_off = 0; m_hi = 0;
  endtask

  task automatic check_outs();
    check("out_valid", OUT_VALID, m_valid);
    check("op_x", OP_X, m_x);
    check("op_y", OP_Y, m_y);
    check("sht_amount", SHT_AMOUNT, m_sht);
    check("pc_offset", PC_OFFSET, m_off);
    check("bl_pend", BL_PEND, m_pend);
    check("bl_orphan", BL_ORPHAN, m_orph);
  endtask

  task automatic step();
    bit acc;
    longint x, y, sh, imm, i11;
    #1;
    check("in_ready", IN_READY, !m_valid || OUT_READY);
    acc = IN_VALID && (!m_valid || OUT_READY) && !FLUSH;
    imm = imm_of(IMM_SEL, INST);
    i11 = INST % 2048;
    x = RN_SEL == 0 ? IF_PC : RN_SEL == 1 ? pick(RF_RD, 1, SRC_X_IDX) : RN_SEL == 2 ? pick(RF_RN, 1, SRC_X_IDX) : 0;
    y = RM_SEL ? pick(RF_RM, 1, SRC_Y_IDX) : imm;
    sh = SHT_SEL == 0 ? (INST / 64) % 32 : SHT_SEL == 1 ? y % 256 : SHT_SEL == 2 ? 12 :
         SHT_SEL == 3 ? 2 : SHT_SEL == 4 ? 1 : 0;
    @(posedge CLK);
    if (FLUSH) begin
      m_valid = 0; m_pend = 0;
    end else if (acc) begin
      m_valid = 1; m_x = x; m_y = y; m_sht = sh;
      if (IS_BL_H2) begin
        m_off = m_pend ? (m_hi + i11 * 2) % M : i11 * 2;
        m_orph = !m_pend; m_pend = 0;
      end else if (IS_BL_H1) begin
        m_hi = (sx(i11, 11) * 4096) % M;
        m_off = m_hi; m_orph = m_pend; m_pend = 1;
      end else begin
        m_off = (imm * 2) % M; m_orph = m_pend; m_pend = 0;
      end
    end else if (OUT_READY) m_valid = 0;
    #1;
    check_outs();
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outs();
    check("rst_in_ready", IN_READY, 1);
    @(negedge CLK);
    RESETn = 1;
    // forwarding: both entries match, entry 0 wins over RF_RN
    idle_in(); IN_VALID = 1; RN_SEL = 2; RF_RN = 32'h100; SRC_X_IDX = 3;
    FWD_VALID = 2'b11; FWD_IDX = {4'd3, 4'd3}; FWD_DATA = {32'hBBBB, 32'hAAAA};
    step();
    check("fwd_x", OP_X, 32'hAAAA);
    // BL pair
    idle_in(); IN_VALID = 1; IS_BL_H1 = 1; INST = 16'h07FF;
    step();
    check("bl_h1_off", PC_OFFSET, 32'hFFFFF000);
    check("bl_h1_pend", BL_PEND, 1);
    IS_BL_H1 = 0; IS_BL_H2 = 1; INST = 16'h0004;
    step();
    check("bl_h2_off", PC_OFFSET, 32'hFFFFF008);
    check("bl_h2_pend", BL_PEND, 0);
    check("bl_h2_orph", BL_ORPHAN, 0);
    // backpressure
    idle_in(); IN_VALID = 1; OUT_READY = 0;
    for (int k = 0; k < 3; k++) begin
      INST = 16'($urandom); IMM_SEL = 3'($urandom); RF_RN = $urandom; RN_SEL = 2;
      step();
      check("stall_ready", IN_READY, 0);
      check("stall_hold", PC_OFFSET, 32'hFFFFF008);
    end
    OUT_READY = 1; IMM_SEL = 3; INST = 16'h0021;
    step();
    check("stall_load", PC_OFFSET, 32'h42);
    // orphaned halves
    idle_in(); IN_VALID = 1; IS_BL_H1 = 1; INST = 16'h0001;
    step();
    IS_BL_H1 = 0; IMM_SEL = 0; INST = 16'h01C0;
    step();
    check("orph_add", BL_ORPHAN, 1);
    check("orph_add_pend", BL_PEND, 0);
    IS_BL_H2 = 1; INST = 16'h0010;
    step();
    check("orph_h2", BL_ORPHAN, 1);
    check("orph_h2_off", PC_OFFSET, 32'h20);
    // flush while H1 held
    idle_in(); IN_VALID = 1; IS_BL_H1 = 1; INST = 16'h0123;
    step();
    IS_BL_H1 = 0; IS_BL_H2 = 1; FLUSH = 1;
    step();
    check("flush_valid", OUT_VALID, 0);
    check("flush_pend", BL_PEND, 0);
    // async reset between BL halves
    idle_in(); IN_VALID = 1; IS_BL_H1 = 1; INST = 16'h0456;
    step();
    #2;
    RESETn = 0;
    #1;
    model_reset();
    check_outs();
    check("rst_mid_ready", IN_READY, 1);
    @(negedge CLK);
    RESETn = 1;
    idle_in(); IN_VALID = 1; IS_BL_H2 = 1; INST = 16'h0003;
    step();
    check("rst_orph_h2", BL_ORPHAN, 1);
    for (int k = 0; k < 1500; k++) begin
      rand_in();
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_dp_pipe.md
ID_DP_PIPE -- requirements
Module: id_dp_pipe

Interface
REQ-001 SHALL have parameters: DW default 32, operand/PC width (min 32); NFWD default 2, forwarding sources; SHW default 8, shift-amount width.
REQ-002 SHALL have ports (name direction width meaning):
 CLK  in  1  sole clock, rising edge
 RESETn  in  1  reset, asynchronous, active-low
 IN_VALID  in  1  decode inputs valid
 IN_READY  out  1  stage can accept
 INST  in  16  Thumb instruction
 IF_PC  in  DW  fetch PC
 RF_RD, RF_RN, RF_RM  in  DW each  register-file read data
 SRC_X_IDX, SRC_Y_IDX  in  4 each  register index behind X / Y operand
 RN_SEL  in  2  X source: 0 IF_PC, 1 RF_RD, 2 RF_RN
 RM_SEL  in  1  Y source: 0 immediate, 1 RF_RM
 IMM_SEL  in  3  0 imm3, 1 imm5, 2 imm7, 3 imm8, 4 imm8s, 5 imm11, 6 imm11s
 SHT_SEL  in  3  0 INST[10:6], 1 Y[7:0], 2 const 12, 3 const 2, 4 const 1
 IS_BL_H1, IS_BL_H2  in  1 each  long-branch prefix / suffix
 FWD_VALID  in  NFWD  forwarding entry valid
 FWD_IDX  in  4*NFWD  forwarding destination indices
 FWD_DATA  in  DW*NFWD  forwarding data
 FLUSH  in  1  discard stage contents
 OUT_VALID  out  1  registered outputs valid
 OUT_READY  in  1  downstream accepts
 OP_X, OP_Y  out  DW each  registered operands
 SHT_AMOUNT  out  SHW  registered shift amount
 PC_OFFSET  out  DW  registered branch offset
 BL_PEND  out  1  BL prefix held, suffix awaited
 BL_ORPHAN  out  1  registered: this output is an unpaired BL half

Function
REQ-003 Immediates SHALL be INST[8:6], [10:6], [6:0], [7:0], [10:0] zero-extended to DW; imm8s, imm11s sign-extend INST[7]/INST[10]; IMM_SEL 7 yields 0.
REQ-004 X SHALL be forwarded when RN_SEL is 1 or 2 and any FWD_VALID[i] with FWD_IDX[i]==SRC_X_IDX; lowest i wins; RN_SEL 0 never forwarded.
REQ-005 Y SHALL be forwarded likewise only when RM_SEL=1, compared against SRC_Y_IDX.
REQ-006 SHT_SEL 1 SHALL use the post-forwarding Y[7:0]; selected value truncated/zero-extended to SHW; SHT_SEL 5-7 yield 0.
REQ-007 IN_READY SHALL equal !OUT_VALID || OUT_READY (combinational, no bubble at full throughput).
REQ-008 Accept = IN_VALID && IN_READY && !FLUSH; on accept all outputs load at the next edge and OUT_VALID=1.
REQ-009 OUT_VALID SHALL clear on OUT_READY without accept; outputs SHALL hold while OUT_VALID && !OUT_READY.
REQ-010 FLUSH SHALL clear OUT_VALID and return BL FSM to IDLE next edge, overriding simultaneous accept.
REQ-011 BL FSM states IDLE, H1_HELD; BL_PEND=1 only in H1_HELD.
REQ-012 Accepted IS_BL_H1: BL_HI <= imm11s<<12; PC_OFFSET <= imm11s<<12; go H1_HELD (also from H1_HELD, overwrite, BL_ORPHAN=1).
REQ-013 Accepted IS_BL_H2 in H1_HELD: PC_OFFSET <= BL_HI + (imm11<<1) mod 2^DW; go IDLE; BL_ORPHAN=0.
REQ-014 Accepted IS_BL_H2 in IDLE: PC_OFFSET <= imm11<<1; BL_ORPHAN=1; stay IDLE.
REQ-015 Other accepted instruction: PC_OFFSET <= selected immediate<<1 mod 2^DW; in H1_HELD go IDLE with BL_ORPHAN=1; else BL_ORPHAN=0.
REQ-016 IS_BL_H1 and IS_BL_H2 both high SHALL be treated as IS_BL_H2.
REQ-017 FSM SHALL change state only on accept or FLUSH.

Reset
REQ-018 RESETn low SHALL asynchronously set OUT_VALID, OP_X, OP_Y, SHT_AMOUNT, PC_OFFSET, BL_HI, BL_ORPHAN to 0 and FSM to IDLE (BL_PEND=0), including mid-BL pair; IN_READY=1 after reset.
REQ-019 Release SHALL be sampled synchronously; first accept possible on first edge after release.

Verification
REQ-020 RN_SEL=2, RF_RN=0x100, SRC_X_IDX=3, FWD_VALID=2'b11, FWD_IDX={3,3}, FWD_DATA={0xBBBB,0xAAAA} -> OP_X=0xAAAA.
REQ-021 INST[10:0]=0x7FF H1 then INST[10:0]=0x004 H2 -> PC_OFFSET 0xFFFFF000 then 0xFFFFF008; BL_PEND 1 then 0.
REQ-022 OUT_READY=0 three cycles, IN_VALID=1 -> IN_READY=0, outputs stable; OUT_READY=1 -> next input loads next edge.
REQ-023 H1 accepted, then ADD (non-BL) -> BL_ORPHAN=1 with ADD, BL_PEND=0; lone H2 in IDLE -> BL_ORPHAN=1.
REQ-024 FLUSH with IN_VALID=1 while H1_HELD -> OUT_VALID=0, BL_PEND=0 next edge, input dropped.
REQ-025 RESETn low mid-stream between BL halves -> all outputs 0 immediately; subsequent H2 reports BL_ORPHAN=1.
